regfile_mp: RTL and testbench
=============================

# regfile_mp

Multi-ported integer register file for the pipelined core, generalising the single-write/two-read file. It has NWRITE write ports and NREAD read ports, plus a per-register pending (scoreboard) bit that decode uses for RAW hazard detection. Decode reads it and sets pending bits at issue. Writeback writes it and clears pending bits. Register 0 is hardwired to zero and is never pending.

## Interface
Parameters:
- N, 5: address bits; 2**N registers.
- WIDTH, 32: data bits per register.
- NREAD, 2: read ports (1–4).
- NWRITE, 2: write ports (1–2).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wenable  in  NWRITE  per-port write enable.
- reg_in  in  NWRITE*N  per-port destination address; port p occupies bits [p*N +: N].
- din  in  NWRITE*WIDTH  per-port write data.
- ra  in  NREAD*N  per-port read address.
- rdata  out  NREAD*WIDTH  per-port read data.
- rbusy  out  NREAD  pending bit of each read address.
- issue_valid  in  1  an instruction with destination issue_rd issues this cycle.
- issue_rd  in  N  destination being marked pending.
- flush  in  1  synchronously clear all pending bits (pipeline squash).

## Operation
- Storage: 2**N × WIDTH flops plus 2**N pending bits.
- Write:
  - On the clk edge, port p with wenable[p]=1 and reg_in[p]!=0 writes din[p].
  - If both ports target the same address, port NWRITE-1 wins.
  - Writes to r0 are dropped.
- Pending update, evaluated per register, highest priority first:
  1. flush=1 → clear every pending bit.
  2. issue_valid=1 and issue_rd==r, r!=0 → set; this wins over a same-cycle write clear.
  3. Any enabled write port targeting r → clear.
  4. Otherwise → hold.
- Pending bit 0 is constant 0.
- Read is combinational: rdata[q] = reg[ra[q]] and rbusy[q] = pending[ra[q]].
- ra[q]==0 always gives rdata 0 and rbusy 0.
- A write to an address that is not pending is legal; the data is written and pending stays 0.

## Timing
- Reset (rst=0): all registers 0 and all pending bits 0, asynchronously. rdata and rbusy are therefore 0 during reset.
- Read latency: 0 cycles (combinational from ra).
- Without bypass, a write becomes visible on rdata the cycle after its clk edge.
- Issue latency: pending is set on the edge in which issue_valid=1; rbusy goes high the following cycle.
- Reset asserted mid-operation discards in-flight writes and issues. The first edge after rst rises behaves as a normal cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Write→read forwarding within the same cycle. If any enabled write port has reg_in==ra[q] (non-zero), rdata[q] takes that port's din; on a dual-port collision, port NWRITE-1 wins.
  - rbusy[q] is forced to 0 in that case, unless issue_valid targets the same address this cycle; the issue has no same-cycle effect on rbusy.
- Undefined: no forwarding. rdata and rbusy reflect state as of the last edge only.

## Structure
- Package regfile_pkg:
  - Constants for default N, WIDTH, NREAD and NWRITE.
  - Typedef reg_addr_t (logic [N-1:0]).
  - Typedef reg_data_t (logic [WIDTH-1:0]).
  - Localparam ZERO_REG = 0.
- Sub-module regfile_scoreboard owns the pending bits:
  - Inputs: issue, write-clear and flush.
  - Outputs: the pending vector.
  - The top module holds the data array and the read muxes.

## Test plan
- Reset: drive rst=0 mid-run after writing r5=0xDEADBEEF, then release. ra0=5 → rdata0=0 and rbusy0=0.
- Dual-write collision: wenable=2'b11, both ports reg_in=7, din0=0x11, din1=0x22. Next cycle ra0=7 → 0x22.
- r0 protection: write 0xFFFFFFFF to r0 and issue_rd=0. ra0=0 → rdata0=0 and rbusy0=0 on every later cycle.
- Scoreboard: issue_rd=9, then next cycle rbusy=1 for ra=9. A write to r9 clears rbusy on the following cycle. Issue plus write to r9 in the same cycle → rbusy stays 1. flush → all rbusy 0 next cycle.
- Bypass with REGFILE_BYPASS_EN: wenable0=1, reg_in0=3, din0=0xABCD and ra1=3 in the same cycle → rdata1=0xABCD, rbusy1=0 combinationally. Without the macro: old value that cycle, 0xABCD the next.
- Parameter sweep NREAD=4, NWRITE=1, N=4, WIDTH=16: random writes versus a reference array model, all four read ports checked every cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the multi-ported register file.
//   DEFAULT_N / DEFAULT_WIDTH / DEFAULT_NREAD / DEFAULT_NWRITE : default sizing
//   reg_addr_t : register index at the default address width
//   reg_data_t : register contents at the default data width
//   ZERO_REG   : index of the hardwired-zero register
package regfile_pkg;

   localparam int DEFAULT_N      = 5;
   localparam int DEFAULT_WIDTH  = 32;
   localparam int DEFAULT_NREAD  = 2;
   localparam int DEFAULT_NWRITE = 2;

   localparam int ZERO_REG = 0;

   typedef logic [DEFAULT_N-1:0]     reg_addr_t;
   typedef logic [DEFAULT_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Holds one pending bit per register, used by decode for RAW hazard detection.
//   clk        : core clock, pending bits update on the rising edge
//   rst        : asynchronous active-low reset, clears every pending bit
//   issueValid : an instruction issues this cycle with destination issueRd
//   issueRd    : destination being marked pending
//   wrEnable   : per-write-port enable, an enabled write clears its target
//   wrAddr     : per-write-port destination, port p at [p*N +: N]
//   flush      : clears every pending bit on the next edge
//   pending    : current pending vector, bit 0 is always 0
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int N      = DEFAULT_N,
   parameter int NWRITE = DEFAULT_NWRITE
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                issueValid,
   input  logic [N-1:0]        issueRd,
   input  logic [NWRITE-1:0]   wrEnable,
   input  logic [NWRITE*N-1:0] wrAddr,
   input  logic                flush,
   output logic [2**N-1:0]     pending
);

   localparam int NREGS = 2**N;

   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;
   logic [NREGS-1:0] writeHit;

   // Decode which registers are targeted by any enabled write port this cycle.
   always_comb begin
      writeHit = '0;
      for (int p = 0; p < NWRITE; p++) begin
         if (wrEnable[p]) begin
            writeHit[wrAddr[p*N +: N]] = 1'b1;
         end
      end
   end

   // Per-register priority: flush beats issue, issue beats a same-cycle write
   // clear, otherwise hold. Register 0 can never become pending.
   always_comb begin
      pending_d = pending_q;
      for (int r = 1; r < NREGS; r++) begin
         if (flush) begin
            pending_d[r] = 1'b0;
         end else if (issueValid && (issueRd == N'(r))) begin
            pending_d[r] = 1'b1;
         end else if (writeHit[r]) begin
            pending_d[r] = 1'b0;
         end
      end
      pending_d[ZERO_REG] = 1'b0;
   end

   // Pending state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-ported integer register file with a per-register pending scoreboard.
// Register 0 reads as zero and is never pending.
//   clk         : core clock, all state updates on the rising edge
//   rst         : asynchronous active-low reset, clears data and pending bits
//   wenable     : per-write-port enable
//   reg_in      : per-write-port destination, port p at [p*N +: N]
//   din         : per-write-port data, port p at [p*WIDTH +: WIDTH]
//   ra          : per-read-port address, port q at [q*N +: N]
//   rdata       : per-read-port data (combinational)
//   rbusy       : pending bit of each read address (combinational)
//   issue_valid : mark issue_rd pending on this edge
//   issue_rd    : destination being marked pending
//   flush       : clear every pending bit on this edge
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// onto the read ports; otherwise reads reflect state as of the last edge.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int N      = DEFAULT_N,
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int NREAD  = DEFAULT_NREAD,
   parameter int NWRITE = DEFAULT_NWRITE
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NWRITE-1:0]       wenable,
   input  logic [NWRITE*N-1:0]     reg_in,
   input  logic [NWRITE*WIDTH-1:0] din,
   input  logic [NREAD*N-1:0]      ra,
   output logic [NREAD*WIDTH-1:0]  rdata,
   output logic [NREAD-1:0]        rbusy,
   input  logic                    issue_valid,
   input  logic [N-1:0]            issue_rd,
   input  logic                    flush
);

   localparam int NREGS = 2**N;
   localparam logic [N-1:0] ZERO_ADDR = N'(ZERO_REG);

   logic [WIDTH-1:0] regFile_q [NREGS];
   logic [WIDTH-1:0] regFile_d [NREGS];
   logic [NREGS-1:0] pending;

   // Apply the write ports in ascending order so the highest-numbered port
   // wins a same-address collision; r0 stays zero regardless.
   always_comb begin
      regFile_d = regFile_q;
      for (int p = 0; p < NWRITE; p++) begin
         if (wenable[p] && (reg_in[p*N +: N] != ZERO_ADDR)) begin
            regFile_d[reg_in[p*N +: N]] = din[p*WIDTH +: WIDTH];
         end
      end
      regFile_d[ZERO_REG] = '0;
   end

   // Data array; reset wipes every register so in-flight writes are lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regFile_q[r] <= '0;
         end
      end else begin
         regFile_q <= regFile_d;
      end
   end

   regfile_scoreboard #(
      .N      (N),
      .NWRITE (NWRITE)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .issueValid (issue_valid),
      .issueRd    (issue_rd),
      .wrEnable   (wenable),
      .wrAddr     (reg_in),
      .flush      (flush),
      .pending    (pending)
   );

   // Combinational read muxes. With forwarding enabled, a same-cycle write to
   // the read address supplies the data and hides the pending bit, except when
   // the same address is also being issued, where the stored pending bit shows.
   always_comb begin
      rdata = '0;
      rbusy = '0;
      for (int q = 0; q < NREAD; q++) begin
         if (ra[q*N +: N] != ZERO_ADDR) begin
            rdata[q*WIDTH +: WIDTH] = regFile_q[ra[q*N +: N]];
            rbusy[q] = pending[ra[q*N +: N]];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NWRITE; p++) begin
               if (wenable[p] && (reg_in[p*N +: N] == ra[q*N +: N])) begin
                  rdata[q*WIDTH +: WIDTH] = din[p*WIDTH +: WIDTH];
                  rbusy[q] = (issue_valid && (issue_rd == ra[q*N +: N])) ?
                             pending[ra[q*N +: N]] : 1'b0;
               end
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Bench for regfile_mp: a default-sized instance (A) and a 4-read/1-write,
// 16-register, 16-bit instance (B), both compared against array models.
module tb_regfile_mp;

   logic clk;
   logic rst;

   logic [1:0]  aWen;
   logic [9:0]  aRegIn;
   logic [63:0] aDin;
   logic [9:0]  aRa;
   logic [63:0] aRdata;
   logic [1:0]  aRbusy;
   logic        aIssueValid;
   logic [4:0]  aIssueRd;
   logic        aFlush;

   logic [0:0]  bWen;
   logic [3:0]  bRegIn;
   logic [15:0] bDin;
   logic [15:0] bRa;
   logic [63:0] bRdata;
   logic [3:0]  bRbusy;
   logic        bIssueValid;
   logic [3:0]  bIssueRd;
   logic        bFlush;

   logic [31:0] memA [32];
   bit          pendA [32];
   logic [15:0] memB [16];
   bit          pendB [16];

   int compareCount;
   int mismatchCount;

   regfile_mp #(.N(5), .WIDTH(32), .NREAD(2), .NWRITE(2)) dutA (
      .clk         (clk),
      .rst         (rst),
      .wenable     (aWen),
      .reg_in      (aRegIn),
      .din         (aDin),
      .ra          (aRa),
      .rdata       (aRdata),
      .rbusy       (aRbusy),
      .issue_valid (aIssueValid),
      .issue_rd    (aIssueRd),
      .flush       (aFlush)
   );

   regfile_mp #(.N(4), .WIDTH(16), .NREAD(4), .NWRITE(1)) dutB (
      .clk         (clk),
      .rst         (rst),
      .wenable     (bWen),
      .reg_in      (bRegIn),
      .din         (bDin),
      .ra          (bRa),
      .rdata       (bRdata),
      .rbusy       (bRbusy),
      .issue_valid (bIssueValid),
      .issue_rd    (bIssueRd),
      .flush       (bFlush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count a comparison and report it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Drive every input of instance A.
   task automatic applyStimulus(input logic [1:0] wen, input logic [9:0] regIn,
                                input logic [63:0] dataIn, input logic [9:0] readAddr,
                                input logic issueValid, input logic [4:0] issueRd,
                                input logic flushIn);
      aWen        = wen;
      aRegIn      = regIn;
      aDin        = dataIn;
      aRa         = readAddr;
      aIssueValid = issueValid;
      aIssueRd    = issueRd;
      aFlush      = flushIn;
   endtask

   task automatic clearModels();
      for (int r = 0; r < 32; r++) begin
         memA[r]  = '0;
         pendA[r] = 1'b0;
      end
      for (int r = 0; r < 16; r++) begin
         memB[r]  = '0;
         pendB[r] = 1'b0;
      end
   endtask

   // Expected read results for both instances from the current inputs.
   task automatic checkReads();
      for (int q = 0; q < 2; q++) begin
         logic [4:0]  addr;
         logic [31:0] expData;
         logic        expBusy;
         addr    = aRa[q*5 +: 5];
         expData = (addr == 0) ? 32'h0 : memA[addr];
         expBusy = (addr == 0) ? 1'b0 : pendA[addr];
`ifdef REGFILE_BYPASS_EN
         for (int p = 0; p < 2; p++) begin
            if (addr != 0 && aWen[p] && aRegIn[p*5 +: 5] == addr) begin
               expData = aDin[p*32 +: 32];
               expBusy = (aIssueValid && aIssueRd == addr) ? pendA[addr] : 1'b0;
            end
         end
`endif
         checkOutput($sformatf("A.rdata%0d", q), aRdata[q*32 +: 32], expData);
         checkOutput($sformatf("A.rbusy%0d", q), {31'b0, aRbusy[q]}, {31'b0, expBusy});
      end
      for (int q = 0; q < 4; q++) begin
         logic [3:0]  addr;
         logic [15:0] expData;
         logic        expBusy;
         addr    = bRa[q*4 +: 4];
         expData = (addr == 0) ? 16'h0 : memB[addr];
         expBusy = (addr == 0) ? 1'b0 : pendB[addr];
`ifdef REGFILE_BYPASS_EN
         if (addr != 0 && bWen[0] && bRegIn == addr) begin
            expData = bDin;
            expBusy = (bIssueValid && bIssueRd == addr) ? pendB[addr] : 1'b0;
         end
`endif
         checkOutput($sformatf("B.rdata%0d", q), {16'b0, bRdata[q*16 +: 16]}, {16'b0, expData});
         checkOutput($sformatf("B.rbusy%0d", q), {31'b0, bRbusy[q]}, {31'b0, expBusy});
      end
   endtask

   // Model of one rising edge: last enabled port wins, r0 never changes,
   // pending follows flush > issue > write-clear > hold.
   task automatic modelEdge();
      for (int p = 0; p < 2; p++) begin
         if (aWen[p] && aRegIn[p*5 +: 5] != 0) memA[aRegIn[p*5 +: 5]] = aDin[p*32 +: 32];
      end
      for (int r = 1; r < 32; r++) begin
         bit hit;
         hit = 1'b0;
         for (int p = 0; p < 2; p++) begin
            if (aWen[p] && aRegIn[p*5 +: 5] == r) hit = 1'b1;
         end
         if (aFlush) pendA[r] = 1'b0;
         else if (aIssueValid && aIssueRd == r) pendA[r] = 1'b1;
         else if (hit) pendA[r] = 1'b0;
      end
      if (bWen[0] && bRegIn != 0) memB[bRegIn] = bDin;
      for (int r = 1; r < 16; r++) begin
         if (bFlush) pendB[r] = 1'b0;
         else if (bIssueValid && bIssueRd == r) pendB[r] = 1'b1;
         else if (bWen[0] && bRegIn == r) pendB[r] = 1'b0;
      end
   endtask

   // One cycle: check reads mid-cycle, then advance the models on the edge.
   task automatic tick();
      @(negedge clk);
      checkReads();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      rst = 1'b0;
      applyStimulus(2'b00, '0, '0, 10'd5, 1'b0, 5'd0, 1'b0);
      bWen = '0; bRegIn = '0; bDin = '0; bRa = '0;
      bIssueValid = 1'b0; bIssueRd = '0; bFlush = 1'b0;
      clearModels();

      #3;
      checkOutput("reset_rdata", aRdata[31:0], 32'h0);
      checkOutput("reset_rbusy", {30'b0, aRbusy}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      $display("[TB] write r5 then reset");
      applyStimulus(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 10'd5, 1'b1, 5'd5, 1'b0);
      tick();
      applyStimulus(2'b00, '0, '0, 10'd5, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("pre_reset_r5", aRdata[31:0], 32'hDEADBEEF);
      checkOutput("pre_reset_busy5", {31'b0, aRbusy[0]}, 32'h1);
      applyStimulus(2'b01, {5'd0, 5'd5}, {32'h0, 32'h01234567}, 10'd5, 1'b1, 5'd6, 1'b0);
      rst = 1'b0;
      clearModels();
      #1;
      checkOutput("reset_r5", aRdata[31:0], 32'h0);
      checkOutput("reset_busy5", {31'b0, aRbusy[0]}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("reset_inflight_r5", aRdata[31:0], 32'h0);
      applyStimulus(2'b00, '0, '0, {5'd6, 5'd5}, 1'b0, 5'd0, 1'b0);
      rst = 1'b1;
      tick();
      checkOutput("post_reset_r5", aRdata[31:0], 32'h0);
      checkOutput("post_reset_busy6", {31'b0, aRbusy[1]}, 32'h0);

      $display("[TB] dual-write collision");
      applyStimulus(2'b11, {5'd7, 5'd7}, {32'h22, 32'h11}, 10'd0, 1'b0, 5'd0, 1'b0);
      tick();
      applyStimulus(2'b00, '0, '0, 10'd7, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("collision_r7", aRdata[31:0], 32'h22);
      tick();

      $display("[TB] r0 protection");
      applyStimulus(2'b11, {5'd0, 5'd0}, {32'hFFFFFFFF, 32'hFFFFFFFF}, 10'd0, 1'b1, 5'd0, 1'b0);
      tick();
      applyStimulus(2'b00, '0, '0, 10'd0, 1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("r0_rdata", aRdata[31:0], 32'h0);
         checkOutput("r0_rbusy", {31'b0, aRbusy[0]}, 32'h0);
         tick();
      end

      $display("[TB] scoreboard");
      applyStimulus(2'b00, '0, '0, 10'd9, 1'b1, 5'd9, 1'b0);
      tick();
      applyStimulus(2'b00, '0, '0, 10'd9, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("sb_set9", {31'b0, aRbusy[0]}, 32'h1);
      applyStimulus(2'b01, {5'd0, 5'd9}, {32'h0, 32'h99}, 10'd9, 1'b0, 5'd0, 1'b0);
      tick();
      applyStimulus(2'b00, '0, '0, 10'd9, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("sb_clear9", {31'b0, aRbusy[0]}, 32'h0);
      applyStimulus(2'b10, {5'd9, 5'd0}, {32'h98, 32'h0}, 10'd9, 1'b1, 5'd9, 1'b0);
      tick();
      applyStimulus(2'b00, '0, '0, {5'd12, 5'd9}, 1'b1, 5'd12, 1'b0);
      #1;
      checkOutput("sb_issue_wins9", {31'b0, aRbusy[0]}, 32'h1);
      checkOutput("sb_data9", aRdata[31:0], 32'h98);
      tick();
      applyStimulus(2'b00, '0, '0, {5'd12, 5'd9}, 1'b0, 5'd0, 1'b1);
      #1;
      checkOutput("sb_pre_flush12", {31'b0, aRbusy[1]}, 32'h1);
      tick();
      applyStimulus(2'b00, '0, '0, {5'd12, 5'd9}, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("sb_flush", {30'b0, aRbusy}, 32'h0);
      tick();

      $display("[TB] forwarding");
      applyStimulus(2'b01, {5'd0, 5'd3}, {32'h0, 32'h1234}, 10'd0, 1'b0, 5'd0, 1'b0);
      tick();
      applyStimulus(2'b01, {5'd0, 5'd3}, {32'h0, 32'hABCD}, {5'd3, 5'd0}, 1'b0, 5'd0, 1'b0);
      #1;
`ifdef REGFILE_BYPASS_EN
      checkOutput("bypass_same_cycle", aRdata[63:32], 32'hABCD);
`else
      checkOutput("bypass_same_cycle", aRdata[63:32], 32'h1234);
`endif
      checkOutput("bypass_busy", {31'b0, aRbusy[1]}, 32'h0);
      tick();
      applyStimulus(2'b00, '0, '0, {5'd3, 5'd0}, 1'b0, 5'd0, 1'b0);
      #1;
      checkOutput("bypass_next_cycle", aRdata[63:32], 32'hABCD);
      tick();

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), 10'($urandom), {$urandom, $urandom},
                       10'($urandom), ($urandom_range(0, 2) == 0), 5'($urandom),
                       ($urandom_range(0, 15) == 0));
         bWen        = 1'($urandom);
         bRegIn      = 4'($urandom);
         bDin        = 16'($urandom);
         bRa         = 16'($urandom);
         bIssueValid = ($urandom_range(0, 3) == 0);
         bIssueRd    = 4'($urandom);
         bFlush      = ($urandom_range(0, 31) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
